// File: rtl/sdr_ram_responder.sv
// sdr_ram_responder: SDRAM device-side model with bank tracking, burst storage and CAS-latency read return
module sdr_ram_responder #(
   parameter int SDR_DW   = 16,
   parameter int SDR_BW   = 2,
   parameter int ROW_BITS = 4,
   parameter int COL_BITS = 8
) (
   input  logic              sdram_clk,
   input  logic              sdram_rst,
   input  logic              sdr_cke,
   input  logic              sdr_cs_n,
   input  logic              sdr_ras_n,
   input  logic              sdr_cas_n,
   input  logic              sdr_we_n,
   input  logic [1:0]        sdr_ba,
   input  logic [12:0]       sdr_addr,
   input  logic [SDR_BW-1:0] sdr_dqm,
   input  logic [SDR_DW-1:0] sdr_din,
   output logic [SDR_DW-1:0] sdr_dout,
   output logic [SDR_BW-1:0] sdr_den_n,
   output logic [3:0]        bank_open,
   output logic              proto_err
);
   localparam int AW = 2 + ROW_BITS + COL_BITS;
   logic [SDR_DW-1:0]   mem [2**AW];
   logic [ROW_BITS-1:0] row_r [4];
   logic [3:0]          ap_pend;
   logic [1:0]          bl;
   logic                cl3;
   logic                b_act, b_wr, b_ap;
   logic [1:0]          b_bank;
   logic [ROW_BITS-1:0] b_row;
   logic [COL_BITS-1:0] b_col;
   logic [2:0]          b_i;
   logic                apc_v;
   logic [1:0]          apc_b;
   logic                p0_v, p1_v;
   logic [SDR_DW-1:0]   p0_d, p1_d;
   logic [SDR_BW-1:0]   dqm_q;
   logic [3:0]          cmd;
   logic                is_lmr, is_ref, is_pre, is_act, is_wr, is_rd, is_bst, is_rw, a10, err, rw_go, trunc, flush;
   logic                g_v, g_wr, g_ap, g_last, o_v;
   logic [1:0]          g_bank;
   logic [ROW_BITS-1:0] g_row;
   logic [COL_BITS-1:0] g_base, g_col, mask_c;
   logic [2:0]          g_i, mask;
   logic [AW-1:0]       g_addr;
   logic [SDR_DW-1:0]   o_d;
   logic                unused_addr;
   // command decode, legality check and the beat the burst generator produces this edge
   always_comb begin
      cmd    = sdr_cke ? {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} : 4'b0111;
      is_lmr = cmd == 4'b0000;
      is_ref = cmd == 4'b0001;
      is_pre = cmd == 4'b0010;
      is_act = cmd == 4'b0011;
      is_wr  = cmd == 4'b0100;
      is_rd  = cmd == 4'b0101;
      is_bst = cmd == 4'b0110;
      is_rw  = is_rd | is_wr;
      a10    = sdr_addr[10];
      err    = (is_act & bank_open[sdr_ba])
             | (is_rw & (!bank_open[sdr_ba] | ap_pend[sdr_ba]))
             | (is_bst & !bank_open[sdr_ba])
             | ((is_ref | is_lmr) & (|bank_open))
             | (is_pre & (a10 ? (|ap_pend) : ap_pend[sdr_ba]))
             | (is_lmr & (sdr_addr[2] | (sdr_addr[6:5] != 2'b01)));
      rw_go  = is_rw & !err;
      trunc  = b_act & (rw_go | (is_bst & !err) | (is_pre & !err & (a10 | (sdr_ba == b_bank))));
      flush  = rw_go & is_wr;
      g_v    = rw_go | (b_act & !trunc);
      g_bank = rw_go ? sdr_ba : b_bank;
      g_row  = rw_go ? row_r[sdr_ba] : b_row;
      g_base = rw_go ? sdr_addr[COL_BITS-1:0] : b_col;
      g_i    = rw_go ? 3'd0 : b_i;
      g_wr   = rw_go ? is_wr : b_wr;
      g_ap   = rw_go ? a10 : b_ap;
      mask   = {bl[1] & bl[0], bl[1], |bl};
      mask_c = COL_BITS'(mask);
      g_last = g_i == mask;
      g_col  = (g_base & ~mask_c) | ((g_base + COL_BITS'(g_i)) & mask_c);
      g_addr = {g_bank, g_row, g_col};
      o_v    = (cl3 ? p1_v : p0_v) & !flush;
      o_d    = cl3 ? p1_d : p0_d;
      unused_addr = ^sdr_addr;
   end
   // bank, mode register, auto-precharge and burst generator state
   always_ff @(posedge sdram_clk) begin
      if (sdram_rst) begin
         bank_open <= '0;
         ap_pend   <= '0;
         proto_err <= 1'b0;
         bl        <= 2'd0;
         cl3       <= 1'b0;
         b_act     <= 1'b0;
         apc_v     <= 1'b0;
      end else begin
         proto_err <= proto_err | err;
         apc_v     <= g_v & g_last & g_ap;
         apc_b     <= g_bank;
         b_act     <= g_v & !g_last;
         b_i       <= g_i + 3'd1;
         if (apc_v) begin
            bank_open[apc_b] <= 1'b0;
            ap_pend[apc_b]   <= 1'b0;
         end
         if (trunc && b_ap) begin
            bank_open[b_bank] <= 1'b0;
            ap_pend[b_bank]   <= 1'b0;
         end
         if (is_act && !err) begin
            bank_open[sdr_ba] <= 1'b1;
            row_r[sdr_ba]     <= sdr_addr[ROW_BITS-1:0];
         end
         if (is_pre && !err) begin
            if (a10) bank_open <= '0;
            else bank_open[sdr_ba] <= 1'b0;
         end
         if (is_lmr && !err) begin
            bl  <= sdr_addr[1:0];
            cl3 <= sdr_addr[4];
         end
         if (rw_go) begin
            ap_pend[sdr_ba] <= a10;
            b_bank <= sdr_ba;
            b_row  <= row_r[sdr_ba];
            b_col  <= sdr_addr[COL_BITS-1:0];
            b_wr   <= is_wr;
            b_ap   <= a10;
         end
      end
   end
   // byte-masked write of the current write beat; contents survive reset
   always_ff @(posedge sdram_clk) begin
      for (int k = 0; k < SDR_BW; k++)
         if (!sdram_rst && g_v && g_wr && !sdr_dqm[k]) mem[g_addr][k*8 +: 8] <= sdr_din[k*8 +: 8];
   end
   // CAS-latency read pipeline with two-cycle read DQM masking on the output register
   always_ff @(posedge sdram_clk) begin
      if (sdram_rst) begin
         p0_v      <= 1'b0;
         p1_v      <= 1'b0;
         dqm_q     <= '0;
         sdr_dout  <= '0;
         sdr_den_n <= '1;
      end else begin
         dqm_q <= sdr_dqm;
         p0_v  <= g_v & !g_wr;
         p0_d  <= mem[g_addr];
         p1_v  <= p0_v & !flush;
         p1_d  <= p0_d;
         for (int k = 0; k < SDR_BW; k++) begin
            sdr_den_n[k]        <= !(o_v & !dqm_q[k]);
            sdr_dout[k*8 +: 8]  <= (o_v & !dqm_q[k]) ? o_d[k*8 +: 8] : 8'd0;
         end
      end
   end
endmodule

// File: tb/tb_sdr_ram_responder.sv
// tb_sdr_ram_responder: directed checks of commands, bursts, latency, masking and errors
module tb_sdr_ram_responder;
   localparam logic [3:0] LMR = 4'b0000, PRE = 4'b0010, ACT = 4'b0011, WR = 4'b0100, RD = 4'b0101, BST = 4'b0110, NOP = 4'b0111;
   logic        sdram_clk = 1'b0;
   logic        sdram_rst, sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
   logic [1:0]  sdr_ba, sdr_dqm, sdr_den_n;
   logic [12:0] sdr_addr;
   logic [15:0] sdr_din, sdr_dout;
   logic [3:0]  bank_open;
   logic        proto_err;
   int          ncmp = 0;
   int          nbad = 0;
   logic [15:0] e1 [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
   logic [15:0] e2 [4] = '{16'h3333, 16'h4444, 16'h1111, 16'h2222};

   sdr_ram_responder dut (
      .sdram_clk(sdram_clk), .sdram_rst(sdram_rst), .sdr_cke(sdr_cke),
      .sdr_cs_n(sdr_cs_n), .sdr_ras_n(sdr_ras_n), .sdr_cas_n(sdr_cas_n), .sdr_we_n(sdr_we_n),
      .sdr_ba(sdr_ba), .sdr_addr(sdr_addr), .sdr_dqm(sdr_dqm), .sdr_din(sdr_din),
      .sdr_dout(sdr_dout), .sdr_den_n(sdr_den_n), .bank_open(bank_open), .proto_err(proto_err)
   );

   always #5 sdram_clk = ~sdram_clk;

   task automatic drive(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a, input logic [1:0] m, input logic [15:0] d);
      {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = c;
      sdr_ba = b;
      sdr_addr = a;
      sdr_dqm = m;
      sdr_din = d;
      @(posedge sdram_clk);
      #1;
   endtask

   task automatic nop();
      drive(NOP, 2'd0, 13'd0, 2'b00, 16'd0);
   endtask

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      ncmp++;
      assert (o === e) else begin
         nbad++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sdram_rst = 1'b1;
      sdr_cke = 1'b1;
      nop();
      nop();
      chk("rst_dout", 32'(sdr_dout), 32'h0);
      chk("rst_den", 32'(sdr_den_n), 32'h3);
      chk("rst_open", 32'(bank_open), 32'h0);
      chk("rst_err", 32'(proto_err), 32'h0);
      sdram_rst = 1'b0;
      drive(LMR, 2'd0, 13'h022, 2'b00, 16'h0);
      drive(ACT, 2'd0, 13'h003, 2'b00, 16'h0);
      chk("act_b0_open", 32'(bank_open), 32'h1);
      drive(WR, 2'd0, 13'h010, 2'b00, 16'h1111);
      drive(NOP, 2'd0, 13'h0, 2'b00, 16'h2222);
      drive(NOP, 2'd0, 13'h0, 2'b00, 16'h3333);
      drive(NOP, 2'd0, 13'h0, 2'b00, 16'h4444);
      drive(RD, 2'd0, 13'h010, 2'b00, 16'h0);
      chk("cl2_pre_den", 32'(sdr_den_n), 32'h3);
      for (int i = 0; i < 4; i++) begin
         nop();
         chk("cl2_beat_data", 32'(sdr_dout), 32'(e1[i]));
         chk("cl2_beat_den", 32'(sdr_den_n), 32'h0);
      end
      nop();
      chk("cl2_post_den", 32'(sdr_den_n), 32'h3);
      drive(PRE, 2'd0, 13'h400, 2'b00, 16'h0);
      drive(LMR, 2'd0, 13'h032, 2'b00, 16'h0);
      drive(ACT, 2'd0, 13'h003, 2'b00, 16'h0);
      drive(RD, 2'd0, 13'h012, 2'b00, 16'h0);
      nop();
      chk("cl3_lat_den", 32'(sdr_den_n), 32'h3);
      for (int i = 0; i < 4; i++) begin
         nop();
         chk("cl3_wrap_data", 32'(sdr_dout), 32'(e2[i]));
         chk("cl3_wrap_den", 32'(sdr_den_n), 32'h0);
      end
      nop();
      chk("cl3_post_den", 32'(sdr_den_n), 32'h3);
      drive(PRE, 2'd0, 13'h400, 2'b00, 16'h0);
      drive(LMR, 2'd0, 13'h020, 2'b00, 16'h0);
      drive(ACT, 2'd0, 13'h003, 2'b00, 16'h0);
      drive(WR, 2'd0, 13'h020, 2'b00, 16'h1234);
      drive(WR, 2'd0, 13'h020, 2'b01, 16'hABCD);
      drive(RD, 2'd0, 13'h020, 2'b00, 16'h0);
      nop();
      chk("wmask_data", 32'(sdr_dout), 32'hAB34);
      chk("wmask_den", 32'(sdr_den_n), 32'h0);
      drive(RD, 2'd0, 13'h020, 2'b10, 16'h0);
      nop();
      chk("rmask_den", 32'(sdr_den_n), 32'h2);
      chk("rmask_data", 32'(sdr_dout), 32'h0034);
      drive(PRE, 2'd0, 13'h400, 2'b00, 16'h0);
      drive(LMR, 2'd0, 13'h023, 2'b00, 16'h0);
      drive(ACT, 2'd0, 13'h003, 2'b00, 16'h0);
      drive(RD, 2'd0, 13'h010, 2'b00, 16'h0);
      nop();
      chk("bst_b0_data", 32'(sdr_dout), 32'h1111);
      chk("bst_b0_den", 32'(sdr_den_n), 32'h0);
      drive(BST, 2'd0, 13'h0, 2'b00, 16'h0);
      chk("bst_b1_data", 32'(sdr_dout), 32'h2222);
      chk("bst_b1_den", 32'(sdr_den_n), 32'h0);
      nop();
      chk("bst_stop_den", 32'(sdr_den_n), 32'h3);
      nop();
      chk("bst_stop_den2", 32'(sdr_den_n), 32'h3);
      chk("no_err_yet", 32'(proto_err), 32'h0);
      drive(ACT, 2'd1, 13'h005, 2'b00, 16'h0);
      chk("act_b1_open", 32'(bank_open), 32'h3);
      drive(RD, 2'd1, 13'h400, 2'b00, 16'h0);
      nop();
      chk("ap_beat0_den", 32'(sdr_den_n), 32'h0);
      repeat (6) nop();
      chk("ap_still_open", 32'(bank_open), 32'h3);
      nop();
      chk("ap_closed", 32'(bank_open), 32'h1);
      chk("ap_no_err", 32'(proto_err), 32'h0);
      drive(RD, 2'd1, 13'h000, 2'b00, 16'h0);
      chk("rd_idle_err", 32'(proto_err), 32'h1);
      chk("rd_idle_den", 32'(sdr_den_n), 32'h3);
      nop();
      chk("rd_idle_den2", 32'(sdr_den_n), 32'h3);
      sdram_rst = 1'b1;
      nop();
      sdram_rst = 1'b0;
      chk("rst2_err", 32'(proto_err), 32'h0);
      chk("rst2_open", 32'(bank_open), 32'h0);
      drive(LMR, 2'd0, 13'h023, 2'b00, 16'h0);
      drive(ACT, 2'd2, 13'h000, 2'b00, 16'h0);
      chk("act_b2_open", 32'(bank_open), 32'h4);
      chk("act_b2_noerr", 32'(proto_err), 32'h0);
      drive(ACT, 2'd2, 13'h000, 2'b00, 16'h0);
      chk("act_twice_err", 32'(proto_err), 32'h1);
      drive(RD, 2'd2, 13'h000, 2'b00, 16'h0);
      nop();
      nop();
      chk("midburst_den", 32'(sdr_den_n), 32'h0);
      sdram_rst = 1'b1;
      nop();
      chk("mid_rst_den", 32'(sdr_den_n), 32'h3);
      chk("mid_rst_open", 32'(bank_open), 32'h0);
      chk("mid_rst_err", 32'(proto_err), 32'h0);
      chk("mid_rst_dout", 32'(sdr_dout), 32'h0);
      sdram_rst = 1'b0;
      nop();
      chk("post_rst_den", 32'(sdr_den_n), 32'h3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end
endmodule
